// File: rtl/uart_packet_tx.sv
// uart_packet_tx: framed 8N1 packet sender (sync, 16-bit length, payload, checksum byte when UART_PKT_CHECKSUM_EN is defined)
module uart_packet_tx #(
  parameter int CLOCKS_PER_BAUD = 33,
  parameter int ADDR_WIDTH = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [7:0]            rd_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tx_o
);
  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef UART_PKT_CHECKSUM_EN
  localparam logic [2:0] S_TRL  = 3'd3;
`else
  localparam logic [2:0] S_TRL  = S_DONE;
`endif
  logic [2:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_bit;
  logic [7:0]            r_sh;
  logic                  r_tx;
  logic [15:0]           r_len;
  logic [1:0]            r_hdr;
  logic [15:0]           r_pidx;
  logic [7:0]            r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_len_zero, w_last_pay, w_load_pay, w_to_tail, w_finish, w_frame_end;
  logic [7:0]            w_byte_nx, w_tail;
  logic [15:0]           w_pidx_nx;
  assign busy_o    = r_state != S_IDLE && r_state != S_DONE;
  assign done_o    = r_state == S_DONE;
  assign tx_o      = r_tx;
  assign rd_addr_o = r_addr;
  // pick the byte that follows the current frame and where the packet goes next
  always_comb begin
    w_len_zero  = r_len == 16'd0;
    w_last_pay  = r_pidx == r_len - 16'd1;
    w_frame_end = busy_o && r_bit == 4'd9 && r_cnt == BAUD_LAST;
    w_load_pay  = (r_state == S_HDR && r_hdr == 2'd2 && !w_len_zero) || (r_state == S_PAY && !w_last_pay);
    w_to_tail   = (r_state == S_HDR && r_hdr == 2'd2 && w_len_zero) || (r_state == S_PAY && w_last_pay);
`ifdef UART_PKT_CHECKSUM_EN
    w_finish    = r_state == S_TRL;
`else
    w_finish    = w_to_tail;
`endif
    w_pidx_nx   = r_state == S_HDR ? 16'd0 : r_pidx + 16'd1;
    w_byte_nx   = r_hdr == 2'd0 ? r_len[15:8] : r_hdr == 2'd1 ? r_len[7:0] : w_load_pay ? r_data : w_tail;
  end
`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0] r_sum;
  // running mod-256 sum of payload bytes as they are loaded into the shifter
  always_ff @(posedge clk_in)
    if (rst_in || (r_state == S_IDLE && start_i)) r_sum <= 8'd0;
    else if (w_frame_end && w_load_pay) r_sum <= r_sum + r_data;
  assign w_tail = r_sum;
`else
  assign w_tail = 8'h00;
`endif
  // packet sequencer, bit serializer and payload prefetch
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= 4'd0;
      r_sh    <= 8'd0;
      r_len   <= 16'd0;
      r_hdr   <= 2'd0;
      r_pidx  <= 16'd0;
      r_data  <= 8'd0;
      r_addr  <= '0;
    end else if (r_state == S_IDLE) begin
      if (start_i) begin
        r_state <= S_HDR;
        r_tx    <= 1'b0;
        r_sh    <= SYNC_BYTE;
        r_cnt   <= '0;
        r_bit   <= 4'd0;
        r_len   <= 16'(len_i);
        r_hdr   <= 2'd0;
        r_addr  <= '0;
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end else begin
      if (r_bit == 4'd9 && r_cnt == '0) r_data <= rd_data_i;
      if (r_cnt != BAUD_LAST) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (r_bit != 4'd9) begin
        r_cnt <= '0;
        r_tx  <= r_bit == 4'd8 ? 1'b1 : r_sh[0];
        r_sh  <= r_sh >> 1;
        r_bit <= r_bit + 4'd1;
      end else begin
        r_cnt   <= '0;
        r_bit   <= 4'd0;
        r_tx    <= w_finish;
        r_sh    <= w_byte_nx;
        r_state <= w_finish ? S_DONE : w_load_pay ? S_PAY : w_to_tail ? S_TRL : r_state;
        if (r_state == S_HDR && r_hdr != 2'd2) r_hdr <= r_hdr + 2'd1;
        if (w_load_pay) r_pidx <= w_pidx_nx;
        if (w_load_pay && w_pidx_nx + 16'd1 < r_len) r_addr <= ADDR_WIDTH'(w_pidx_nx + 16'd1);
      end
    end
  end
endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: directed packet vectors plus busy-start, mid-packet reset and long-length sequences
module tb_uart_packet_tx;
`ifdef UART_PKT_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  typedef struct {
    int          len;
    logic [23:0] pay;
    logic [7:0]  sum;
    int          done_cs;
    int          done_nc;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst, start_i, busy, done, tx;
  logic [15:0] len_i, rd_addr;
  logic [7:0]  rd_data, rd_p1;
  logic [7:0]  mem [0:511];
  logic [7:0]  exp_q [$];
  vec_t        vecs [4];
  int cyc = 0, done_cnt = 0, done_cyc = 0, max_addr = 0, pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;
  uart_packet_tx #(.CLOCKS_PER_BAUD(4)) dut (
    .clk_in(clk), .rst_in(rst), .start_i(start_i), .len_i(len_i), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .busy_o(busy), .done_o(done), .tx_o(tx)
  );
  always @(posedge clk) begin
    rd_p1   <= mem[rd_addr[8:0]];
    rd_data <= rd_p1;
  end
  always @(posedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    cyc++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic build(input int len, input logic [7:0] sum);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
    if (CS) exp_q.push_back(sum);
  endtask
  task automatic run_pkt(input string tag, input int len, input int done_off, input int max_exp, input bit inject);
    int n, t0, dc0, bad_busy;
    logic [9:0] fr;
    n = exp_q.size();
    dc0 = done_cnt;
    bad_busy = 0;
    fr = '0;
    @(negedge clk);
    start_i = 1'b1;
    len_i = 16'(len);
    t0 = cyc;
    for (int c = 1; c <= 40 * n; c++) begin
      @(negedge clk);
      start_i = inject && c == 89;
      if (inject && c == 89) len_i = 16'd5;
      if (c == 1) max_addr = 0;
      if (!busy) bad_busy++;
      if ((c - 1) % 4 == 1) fr[((c - 1) % 40) / 4] = tx;
      if ((c - 1) % 40 == 39) begin
        chk({tag, " start/stop"}, {30'd0, fr[9], fr[0]}, 32'd2);
        chk({tag, " byte"}, {24'd0, fr[8:1]}, {24'd0, exp_q[(c - 1) / 40]});
      end
    end
    chk({tag, " busy held"}, bad_busy, 0);
    @(negedge clk);
    chk({tag, " done_o"}, {31'd0, done}, 1);
    chk({tag, " busy at done"}, {31'd0, busy}, 0);
    chk({tag, " tx idle"}, {31'd0, tx}, 1);
    repeat (3) @(negedge clk);
    chk({tag, " done count"}, done_cnt - dc0, 1);
    chk({tag, " done cycle"}, done_cyc - t0, done_off);
    chk({tag, " max addr"}, max_addr, max_exp);
  endtask
  initial begin
    int t, dc0;
    rst = 1'b1;
    start_i = 1'b0;
    len_i = 16'd0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset tx", {31'd0, tx}, 1);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset addr", {16'd0, rd_addr}, 0);
    rst = 1'b0;
    vecs[0] = '{0, 24'h000000, 8'h00, 161, 121};
    vecs[1] = '{3, 24'h0102FF, 8'h02, 281, 241};
    vecs[2] = '{2, 24'h102000, 8'h30, 241, 201};
    vecs[3] = '{1, 24'h800000, 8'h80, 201, 161};
    for (int v = 0; v < 4; v++) begin
      mem[0] = vecs[v].pay[23:16];
      mem[1] = vecs[v].pay[15:8];
      mem[2] = vecs[v].pay[7:0];
      build(vecs[v].len, vecs[v].sum);
      run_pkt($sformatf("vec%0d", v), vecs[v].len, CS ? vecs[v].done_cs : vecs[v].done_nc,
              vecs[v].len == 0 ? 0 : vecs[v].len - 1, 1'b0);
    end
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    mem[2] = 8'hFF;
    build(3, 8'h02);
    run_pkt("busy start", 3, CS ? 281 : 241, 2, 1'b1);
    dc0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1;
    len_i = 16'd3;
    t = cyc;
    @(negedge clk);
    start_i = 1'b0;
    repeat (161) @(negedge clk);
    chk("pre-reset addr", {16'd0, rd_addr}, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset tx", {31'd0, tx}, 1);
    chk("mid reset busy", {31'd0, busy}, 0);
    chk("mid reset addr", {16'd0, rd_addr}, 0);
    chk("mid reset cycle", cyc - t, 163);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("no done after reset", done_cnt - dc0, 0);
    chk("idle after reset", {31'd0, tx}, 1);
    run_pkt("after reset", 3, CS ? 281 : 241, 2, 1'b0);
    for (int i = 0; i < 300; i++) mem[i] = i[7:0];
    // 0..255 sums to 32640, 256..299 contribute 0..43 = 946; 33586 mod 256 = 8'h32
    build(300, 8'h32);
    chk("long header hi", {24'd0, exp_q[1]}, 32'h01);
    chk("long header lo", {24'd0, exp_q[2]}, 32'h2C);
    run_pkt("len300", 300, CS ? 12161 : 12121, 299, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
